// File: rtl/prog_loader_pkg.sv
// Shared types and sizing for the program loader: FSM states, image depth,
// handshake timeout and counter widths.
package prog_loader_pkg;
  localparam int IMAGE_DEPTH = 16;
  localparam int TIMEOUT_CYC = 255;
  localparam int IDX_W       = 4;
  localparam int CNT_W       = 5;
  localparam int WD_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_LOAD,
    ST_DONE,
    ST_ERROR
  } state_e;
endpackage

// File: rtl/prog_image_ram.sv
// 16x8 program image: synchronous write, asynchronous read, contents survive reset.
module prog_image_ram
  import prog_loader_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [7:0]       rdata_o
);
  logic [7:0] mem_q [IMAGE_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/prog_loader.sv
// Streams a stored image byte-by-byte to a CPU, paced by falling edges of its
// ready request, with overrun and handshake-timeout detection.
//
// state | meaning
// IDLE  | waiting for start, image writable
// ARM   | one-cycle setup, programming asserted
// LOAD  | presenting image[index], counting ready falling edges
// DONE  | CPU reported completion, image writable
// ERROR | overrun or watchdog timeout, image writable
module prog_loader #(
  parameter int IMAGE_DEPTH = prog_loader_pkg::IMAGE_DEPTH,
  parameter int TIMEOUT_CYC = prog_loader_pkg::TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       img_we,
  input  logic [3:0] img_addr,
  input  logic [7:0] img_wdata,
  input  logic       start,
  input  logic       cpu_ready,
  input  logic       cpu_done_load,
  output logic       programming,
  output logic [7:0] prog_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] bytes_sent
);
  import prog_loader_pkg::*;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             ready_q;
  logic             rdy_fall, rdy_edge, idle_like;
  logic [7:0]       ram_rdata;

  assign rdy_fall  = ready_q & ~cpu_ready;
  assign rdy_edge  = ready_q ^ cpu_ready;
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);

  prog_image_ram u_ram (
    .clk     (clk),
    .we_i    (img_we & idle_like),
    .waddr_i (img_addr),
    .wdata_i (img_wdata),
    .raddr_i (idx_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_ARM;
          idx_d   = '0;
          cnt_d   = '0;
          wd_d    = '0;
        end
      end
      ST_ARM: begin
        state_d = ST_LOAD;
        wd_d    = '0;
      end
      ST_LOAD: begin
        wd_d = rdy_edge ? '0 : wd_q + WD_W'(1);
        if (rdy_fall && (cnt_q == CNT_W'(IMAGE_DEPTH))) begin
          state_d = ST_ERROR;
        end else begin
          // A coincident falling edge is counted before completion is honoured.
          if (rdy_fall) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (idx_q != IDX_W'(IMAGE_DEPTH - 1)) idx_d = idx_q + IDX_W'(1);
          end
          if (cpu_done_load) state_d = ST_DONE;
          else if (!rdy_edge && (wd_q == WD_W'(TIMEOUT_CYC - 1))) state_d = ST_ERROR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      ready_q <= cpu_ready;
    end
  end

  assign busy        = (state_q == ST_ARM) || (state_q == ST_LOAD);
  assign programming = busy;
  assign done        = (state_q == ST_DONE);
  assign err         = (state_q == ST_ERROR);
  assign prog_data   = busy ? ram_rdata : 8'h00;
  assign bytes_sent  = cnt_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a vector table for the basic handshake plus
// hand-written sequences for overrun, timeout, reset and write-ordering cases.
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       img_we = 1'b0;
  logic [3:0] img_addr = '0;
  logic [7:0] img_wdata = '0;
  logic       start = 1'b0;
  logic       cpu_ready = 1'b0;
  logic       cpu_done_load = 1'b0;
  logic       programming, busy, done, err;
  logic [7:0] prog_data;
  logic [4:0] bytes_sent;

  int n_vec = 0;
  int n_err = 0;

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .img_we(img_we), .img_addr(img_addr),
    .img_wdata(img_wdata), .start(start), .cpu_ready(cpu_ready),
    .cpu_done_load(cpu_done_load), .programming(programming),
    .prog_data(prog_data), .busy(busy), .done(done), .err(err),
    .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       start;
    logic       ready;
    logic       dl;
    logic       e_prog;
    logic [7:0] e_pd;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
    logic [4:0] e_bytes;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    cpu_ready = 1'b1;
    tick();
    cpu_ready = 1'b0;
    tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {programming, prog_data, busy, done, err, bytes_sent};
  endfunction

  initial begin
    int early_err;

    //          we    addr  wdata  st    rdy   dl    prog  pd     busy  done  err   bytes
    tbl[0] = '{1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 5'd0};
    tbl[1] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 5'd0};
    tbl[2] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 5'd0};
    tbl[3] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 5'd1};
    tbl[4] = '{1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 5'd1};
    tbl[5] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 5'd2};
    tbl[6] = '{1'b1, 4'h3, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 5'd2};
    tbl[7] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd3};
    tbl[8] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd3};
    tbl[9] = '{1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 5'd0};

    // Reset state
    tick();
    chk("reset_outputs", 32'(outs()), 32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0}));
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      img_we = 1'b1; img_addr = 4'(i); img_wdata = 8'(16 + i);
      tick();
    end
    img_we = 1'b0;
    chk("idle_after_writes", 32'(outs()), 32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0}));

    // Table: short load, start ignored in LOAD, write ignored in LOAD,
    // coincident fall + done_load, DONE hold, restart from DONE.
    for (int v = 0; v < 10; v++) begin
      img_we = tbl[v].we; img_addr = tbl[v].addr; img_wdata = tbl[v].wdata;
      start = tbl[v].start; cpu_ready = tbl[v].ready; cpu_done_load = tbl[v].dl;
      tick();
      chk($sformatf("table_vec%0d", v), 32'(outs()),
          32'({tbl[v].e_prog, tbl[v].e_pd, tbl[v].e_busy, tbl[v].e_done, tbl[v].e_err, tbl[v].e_bytes}));
    end
    img_we = 1'b0; start = 1'b0; cpu_ready = 1'b0; cpu_done_load = 1'b0;

    // Full 16-byte load (already in ARM)
    tick();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_pd%0d", i), 32'(prog_data), 32'(16 + i));
      pulse();
    end
    chk("full_bytes16", 32'(bytes_sent), 32'd16);
    chk("full_index_sat", 32'(prog_data), 32'h1F);
    cpu_done_load = 1'b1; tick(); cpu_done_load = 1'b0;
    chk("full_done", 32'(outs()), 32'({1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd16}));

    // Overrun: 17th falling edge
    start = 1'b1; tick(); start = 1'b0; tick();
    for (int i = 0; i < 16; i++) pulse();
    chk("ovr_busy_before", 32'({busy, bytes_sent}), 32'({1'b1, 5'd16}));
    pulse();
    chk("ovr_err", 32'(outs()), 32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd16}));

    // Write during LOAD was ignored; then reset after 5 bytes
    start = 1'b1; tick(); start = 1'b0; tick();
    for (int i = 0; i < 3; i++) pulse();
    chk("idx3_not_overwritten", 32'(prog_data), 32'h13);
    pulse(); pulse();
    chk("five_bytes", 32'(bytes_sent), 32'd5);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("reset_mid_load", 32'(outs()), 32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0}));
    start = 1'b1; tick(); start = 1'b0;
    chk("image0_kept", 32'({busy, prog_data}), 32'({1'b1, 8'h10}));

    // Watchdog: 255 LOAD cycles with ready held low
    tick();
    early_err = 0;
    for (int c = 0; c < 254; c++) begin
      tick();
      if (err) early_err++;
    end
    chk("wd_no_early_err", 32'(early_err), 32'd0);
    chk("wd_still_busy", 32'(busy), 32'd1);
    tick();
    chk("wd_err_at_255", 32'({err, programming}), 32'({1'b1, 1'b0}));
    tick();
    chk("error_holds", 32'({err, busy}), 32'({1'b1, 1'b0}));

    // Write and start in the same cycle: ARM presents the new byte
    img_we = 1'b1; img_addr = 4'h0; img_wdata = 8'h5A; start = 1'b1;
    tick();
    img_we = 1'b0; start = 1'b0;
    chk("write_with_start", 32'({busy, prog_data}), 32'({1'b1, 8'h5A}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter IMAGE_DEPTH, default 16, number of image bytes (matches CPU RAM).
REQ-002 Parameter TIMEOUT_CYC, default 255, maximum cycles allowed between handshake events.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 img_we  input  1  image write strobe.
REQ-006 img_addr  input  4  image write address.
REQ-007 img_wdata  input  8  image write data.
REQ-008 start  input  1  single-cycle pulse that begins a load.
REQ-009 cpu_ready  input  1  CPU request for the next byte (CPU ready_for_ui).
REQ-010 cpu_done_load  input  1  CPU signals that programming is complete.
REQ-011 programming  output  1  drives the CPU programming-mode input.
REQ-012 prog_data  output  8  byte presented to the CPU ui_in.
REQ-013 busy  output  1  high in ARM and LOAD.
REQ-014 done  output  1  high in DONE.
REQ-015 err  output  1  high in ERROR.
REQ-016 bytes_sent  output  5  count of bytes consumed in the current or last load, 0..16.

Function
REQ-017 FSM states: IDLE, ARM, LOAD, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR with start=1: go to ARM next edge; clear bytes_sent, index and watchdog.
REQ-019 ARM lasts exactly one cycle, then LOAD; programming=1 from ARM entry.
REQ-020 programming is 1 only in ARM and LOAD; it is 0 on the same edge that enters DONE or ERROR.
REQ-021 prog_data = image[index] combinationally in ARM/LOAD; 8'h00 in all other states.
REQ-022 Index and bytes_sent advance by 1 on each detected cpu_ready 1->0 transition in LOAD.
REQ-023 cpu_ready is registered once; a falling edge is prev=1, cur=0.
REQ-024 LOAD with cpu_done_load=1: go to DONE.
REQ-025 If cpu_done_load and a ready falling edge occur in the same cycle, the byte counts first, then the FSM enters DONE.
REQ-026 Overrun: a falling edge when bytes_sent=IMAGE_DEPTH goes to ERROR; bytes_sent saturates at 16 and the index never wraps.
REQ-027 Watchdog: an 8-bit counter, cleared on ARM entry and on every cpu_ready edge (either direction), increments each LOAD cycle.
REQ-028 When the watchdog reaches TIMEOUT_CYC without cpu_done_load, go to ERROR.
REQ-029 img_we writes img_wdata to image[img_addr] on the clock edge only in IDLE/DONE/ERROR; it is ignored in ARM/LOAD.
REQ-030 img_we and start in the same IDLE cycle: the write completes, and LOAD uses the new byte.
REQ-031 start in ARM/LOAD is ignored.
REQ-032 DONE and ERROR hold until start or reset.
REQ-033 busy, done and err are mutually exclusive and decoded from state.

Reset
REQ-034 rst_n=0 at an edge: state=IDLE, programming=0, prog_data=0, busy=done=err=0, bytes_sent=0, watchdog=0, ready history=0.
REQ-035 Reset during LOAD aborts the load and drops programming at that edge.
REQ-036 Image contents are not cleared by reset.

Structure
REQ-037 Package prog_loader_pkg holds the state enum, IMAGE_DEPTH, TIMEOUT_CYC and the index/counter widths.
REQ-038 Sub-module prog_image_ram provides the 16x8 image: synchronous write, asynchronous read, no reset.
REQ-039 FSM, edge detector, counters and watchdog live in prog_loader.
REQ-040 Target size: 120-400 lines of RTL.

Verification
REQ-041 Write image[i]=8'h10+i, pulse start, then pulse cpu_ready 16 times followed by cpu_done_load -> prog_data steps 8'h10..8'h1F, bytes_sent=16, done=1, programming=0.
REQ-042 Fill a 17th ready pulse before done_load -> err=1, programming=0, bytes_sent=16.
REQ-043 Hold cpu_ready=0 after ARM for 255 cycles -> err=1 on cycle 255, not earlier.
REQ-044 Assert rst_n=0 after 5 bytes -> next cycle state=IDLE, bytes_sent=0, programming=0, image[0] still 8'h10.
REQ-045 img_we to addr 3 (8'hAA) during LOAD -> ignored, and a later load presents 8'h13 at index 3.
REQ-046 Falling edge of ready coincident with done_load after 4 bytes -> bytes_sent=5, done=1.
